// File: rtl/dac_pkg.sv
// Shared types and constants for the pwm_dac output stage.
package dac_pkg;

  localparam int DAC_WIDTH_DEF = 8;

  // Encoding of the sd_sel input.
  localparam logic MODE_PWM = 1'b0;
  localparam logic MODE_SD  = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PWM_RUN = 2'd1,
    SD_RUN  = 2'd2
  } dac_state_t;

endpackage

// File: rtl/tick_gen.sv
// Modulation-rate prescaler: tick is high on the last count of every
// PRESCALE-cycle period. clr holds the count at 0 so a run always starts
// with a full period after the start edge.
module tick_gen #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] pre_cnt;

  assign tick = (pre_cnt == LAST);

  // Count 0..PRESCALE-1 and wrap; cleared by reset or while idle.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/pwm_dac.sv
// 1-bit DAC output stage: fixed-frame PWM or first-order sigma-delta of
// the incoming wave sample.
//
// Handshake: there is no back-pressure. wave is simply sampled on each
// latching edge (frame boundary in PWM, every tick in SD), and
// sample_tick is high for the single cycle following that edge.
module pwm_dac
  import dac_pkg::*;
#(
  parameter int WIDTH    = DAC_WIDTH_DEF,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sd_sel,
  input  logic [WIDTH-1:0] wave,
  output logic             pwm_out,
  output logic             sample_tick,
  output logic             frame_start,
  output logic [1:0]       dbg_state
);

  localparam logic [WIDTH-1:0] PH_MAX = '1;

  dac_state_t       state_q, state_d;
  logic [WIDTH-1:0] ph_q, ph_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic             pwm_d, st_d, fs_d;
  logic             tick;
  logic             pwm_wrap, sd_tick, start, latch;

  assign dbg_state = state_q;

  tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  ((state_q == IDLE) || !en),
    .tick (tick)
  );

  // Latching events: start edge, PWM phase wrap, or any SD tick.
  assign start    = (state_q == IDLE);
  assign pwm_wrap = (state_q == PWM_RUN) && tick && (ph_q == PH_MAX);
  assign sd_tick  = (state_q == SD_RUN) && tick;
  assign latch    = start || pwm_wrap || sd_tick;

  // State register; reset beats everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: en low always idles; mode is re-read only at latch points.
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = IDLE;
    end else if (latch) begin
      state_d = (sd_sel == MODE_SD) ? SD_RUN : PWM_RUN;
    end
  end

  // Next values of the datapath and registered outputs.
  always_comb begin
    ph_d   = ph_q;
    duty_d = duty_q;
    acc_d  = acc_q;
    pwm_d  = 1'b0;
    st_d   = 1'b0;
    fs_d   = 1'b0;
    case (state_d)
      PWM_RUN: begin
        acc_d = '0;
        if (latch) begin
          duty_d = wave;
          ph_d   = '0;
          st_d   = 1'b1;
          fs_d   = 1'b1;
        end else if (tick) begin
          ph_d = ph_q + WIDTH'(1);
        end
        pwm_d = (ph_d < duty_d);
      end
      SD_RUN: begin
        ph_d   = '0;
        duty_d = '0;
        if (latch) begin
          acc_d = {1'b0, acc_q[WIDTH-1:0]} + {1'b0, wave};
          st_d  = 1'b1;
        end
        pwm_d = acc_d[WIDTH];
      end
      default: begin
        ph_d   = '0;
        duty_d = '0;
        acc_d  = '0;
      end
    endcase
  end

  // Datapath and output registers, all cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ph_q        <= '0;
      duty_q      <= '0;
      acc_q       <= '0;
      pwm_out     <= 1'b0;
      sample_tick <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      ph_q        <= ph_d;
      duty_q      <= duty_d;
      acc_q       <= acc_d;
      pwm_out     <= pwm_d;
      sample_tick <= st_d;
      frame_start <= fs_d;
    end
  end

endmodule

// File: tb/tb_pwm_dac.sv
// Directed bench for pwm_dac with PRESCALE=1 and PRESCALE=4 instances
// sharing the same stimulus.
module tb_pwm_dac;
  import dac_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       sd_sel = 1'b0;
  logic [7:0] wave = 8'd0;

  logic       pwm1, st1, fs1;
  logic       pwm4, st4, fs4;
  logic [1:0] dbg1, dbg4;

  int total = 0;
  int bad = 0;
  int hi1, cst1, cfs1, hi4, cst4, cfs4;
  int acc_hi;

  // clock / reset
  always #5 clk = ~clk;

  pwm_dac #(.WIDTH(8), .PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .sd_sel(sd_sel), .wave(wave),
    .pwm_out(pwm1), .sample_tick(st1), .frame_start(fs1), .dbg_state(dbg1)
  );

  pwm_dac #(.WIDTH(8), .PRESCALE(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .sd_sel(sd_sel), .wave(wave),
    .pwm_out(pwm4), .sample_tick(st4), .frame_start(fs4), .dbg_state(dbg4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // advance one clock; inputs are driven and outputs sampled 1 ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // sample n consecutive cycles starting with the one currently visible
  task automatic window(input int n);
    hi1 = 0; cst1 = 0; cfs1 = 0; hi4 = 0; cst4 = 0; cfs4 = 0;
    for (int i = 0; i < n; i++) begin
      hi1 += int'(pwm1); cst1 += int'(st1); cfs1 += int'(fs1);
      hi4 += int'(pwm4); cst4 += int'(st4); cfs4 += int'(fs4);
      step();
    end
  endtask

  initial begin
    // reset state
    rst = 1'b1;
    repeat (3) step();
    chk("rst_pwm", pwm1, 0);
    chk("rst_st", st1, 0);
    chk("rst_fs", fs1, 0);
    chk("rst_state", dbg1, IDLE);
    chk("rst_pwm4", pwm4, 0);
    rst = 1'b0;
    step();
    chk("idle_pwm", pwm1, 0);

    // PWM, wave=64
    wave = 8'd64; sd_sel = MODE_PWM; en = 1'b1;
    step();
    chk("start_st", st1, 1);
    chk("start_fs", fs1, 1);
    chk("start_pwm", pwm1, 1);
    chk("start_state", dbg1, PWM_RUN);
    window(256);
    chk("w64_hi", hi1, 64);
    chk("w64_st", cst1, 1);
    chk("w64_fs", cfs1, 1);
    window(256);
    chk("w64_hi2", hi1, 64);

    // wave 64 -> 192 at clk 100 of a frame
    window(100);
    acc_hi = hi1;
    wave = 8'd192;
    window(156);
    chk("midchg_hi", acc_hi + hi1, 64);
    wave = 8'd0;
    window(256);
    chk("w192_hi", hi1, 192);
    wave = 8'd255;
    window(256);
    chk("w0_hi", hi1, 0);
    chk("w0_fs", cfs1, 1);

    // switch to SD at the next boundary
    sd_sel = MODE_SD; wave = 8'd128;
    window(256);
    chk("w255_hi", hi1, 255);
    chk("sd_entry_st", st1, 1);
    chk("sd_entry_fs", fs1, 0);
    chk("sd_entry_pwm", pwm1, 0);
    chk("sd_entry_state", dbg1, SD_RUN);
    window(16);
    chk("sd128_hi", hi1, 8);
    chk("sd128_st", cst1, 16);
    chk("sd128_fs", cfs1, 0);
    wave = 8'd64;
    window(16);
    chk("sd64_hi", hi1, 4);
    chk("sd64_st", cst1, 16);

    // back to PWM: fresh boundary on the next tick
    sd_sel = MODE_PWM;
    step();
    chk("pwm_back_fs", fs1, 1);
    chk("pwm_back_pwm", pwm1, 1);
    chk("pwm_back_state", dbg1, PWM_RUN);

    // en dropped at clk 50
    window(50);
    chk("pre_drop_hi", hi1, 50);
    en = 1'b0;
    step();
    chk("drop_pwm", pwm1, 0);
    chk("drop_st", st1, 0);
    chk("drop_state", dbg1, IDLE);
    window(5);
    chk("idle_hi", hi1, 0);
    en = 1'b1;
    step();
    chk("reraise_st", st1, 1);
    chk("reraise_fs", fs1, 1);
    window(256);
    chk("reraise_hi", hi1, 64);

    // rst mid-run, with en held high
    window(50);
    rst = 1'b1;
    step();
    chk("rstrun_pwm", pwm1, 0);
    chk("rstrun_state", dbg1, IDLE);
    step();
    chk("rst_en_state", dbg1, IDLE);
    rst = 1'b0;
    step();
    chk("rstrel_st", st1, 1);
    chk("rstrel_pwm", pwm1, 1);
    window(255);
    // en falls exactly on the boundary edge: no sample
    en = 1'b0;
    step();
    chk("bnd_drop_st", st1, 0);
    chk("bnd_drop_fs", fs1, 0);

    // PRESCALE=4, wave=10, sd_sel raised mid-frame
    rst = 1'b1;
    step();
    rst = 1'b0; wave = 8'd10; sd_sel = MODE_PWM; en = 1'b1;
    step();
    chk("p4_start_st", st4, 1);
    chk("p4_start_pwm", pwm4, 1);
    window(512);
    acc_hi = hi4;
    chk("p4_first_fs", cfs4, 1);
    sd_sel = MODE_SD;
    window(512);
    chk("p4_hi", acc_hi + hi4, 40);
    chk("p4_fs_mid", cfs4, 0);
    chk("p4_st_mid", cst4, 0);
    chk("p4_sd_st", st4, 1);
    chk("p4_sd_fs", fs4, 0);
    chk("p4_sd_state", dbg4, SD_RUN);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
